// File: rtl/barrel_pkg.sv
// barrel_pkg: shared mode encodings and helpers
// for the pipelined barrel shifter.
package barrel_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_SLL = 3'd0;
  localparam logic [MODE_W-1:0] MODE_SRL = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SRA = 3'd2;
  localparam logic [MODE_W-1:0] MODE_ROL = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROR = 3'd4;

  function automatic logic is_reserved(
    input logic [MODE_W-1:0] mode
  );
    return mode > MODE_ROR;
  endfunction

endpackage

// File: rtl/barrel_stage.sv
// barrel_stage: one combinational shift/rotate
// step of fixed distance STEP, enabled per transaction.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0]  data,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic              sign,
  output logic [WIDTH-1:0]  result
);

  // Select the STEP-wide move for this mode; reserved
  // modes and disabled steps pass data through.
  always_comb begin
    result = data;
    if (en) begin
      unique case (1'b1)
        (mode == MODE_SLL):
          result = {data[WIDTH-1-STEP:0], {STEP{1'b0}}};
        (mode == MODE_SRL):
          result = {{STEP{1'b0}}, data[WIDTH-1:STEP]};
        (mode == MODE_SRA):
          result = {{STEP{sign}}, data[WIDTH-1:STEP]};
        (mode == MODE_ROL):
          result = {data[WIDTH-1-STEP:0],
                    data[WIDTH-1:WIDTH-STEP]};
        (mode == MODE_ROR):
          result = {data[STEP-1:0], data[WIDTH-1:STEP]};
        default:
          result = data;
      endcase
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: SHW-stage pipelined shifter,
// one stage per shamt bit, shared stall on backpressure.
module barrel_shifter_pipe
  import barrel_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SHW-1:0]    shamt,
  input  logic [MODE_W-1:0] mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_err
);

  logic advance;

  logic              v_q  [SHW];
  logic [WIDTH-1:0]  d_q  [SHW];
  logic [SHW-1:0]    sh_q [SHW];
  logic [MODE_W-1:0] md_q [SHW];
  logic              er_q [SHW];
  logic              sg_q [SHW];

  logic              st_v  [SHW];
  logic [WIDTH-1:0]  st_d  [SHW];
  logic [SHW-1:0]    st_sh [SHW];
  logic [MODE_W-1:0] st_md [SHW];
  logic              st_er [SHW];
  logic              st_sg [SHW];
  logic [WIDTH-1:0]  nx_d  [SHW];

  assign out_valid = v_q[SHW-1];
  assign out_data  = d_q[SHW-1];
  assign out_err   = er_q[SHW-1];
  assign advance   = out_ready | ~out_valid;
  assign in_ready  = advance;

  // Stage inputs: stage 0 from the port, others from
  // the previous register; the sign is fixed at entry.
  always_comb begin
    st_v[0]  = in_valid;
    st_d[0]  = in_data;
    st_sh[0] = shamt;
    st_md[0] = mode;
    st_er[0] = is_reserved(mode);
    st_sg[0] = in_data[WIDTH-1];
    for (int k = 1; k < SHW; k++) begin
      st_v[k]  = v_q[k-1];
      st_d[k]  = d_q[k-1];
      st_sh[k] = sh_q[k-1];
      st_md[k] = md_q[k-1];
      st_er[k] = er_q[k-1];
      st_sg[k] = sg_q[k-1];
    end
  end

  for (genvar k = 0; k < SHW; k++) begin : g_st
    barrel_stage #(
      .WIDTH (WIDTH),
      .STEP  (1 << k)
    ) u_stage (
      .data   (st_d[k]),
      .en     (st_sh[k][k]),
      .mode   (st_md[k]),
      .sign   (st_sg[k]),
      .result (nx_d[k])
    );
  end

  // All stages move together on advance; payload is
  // only captured for valid slots, bubbles clear err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SHW; k++) begin
        v_q[k]  <= 1'b0;
        d_q[k]  <= '0;
        sh_q[k] <= '0;
        md_q[k] <= '0;
        er_q[k] <= 1'b0;
        sg_q[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < SHW; k++) begin
        v_q[k]  <= st_v[k];
        er_q[k] <= st_v[k] & st_er[k];
        if (st_v[k]) begin
          d_q[k]  <= nx_d[k];
          sh_q[k] <= st_sh[k];
          md_q[k] <= st_md[k];
          sg_q[k] <= st_sg[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: directed + random checks
// of the pipelined shifter at WIDTH=8 and WIDTH=32.
module tb_barrel_shifter_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv, ir, ov, ord, oe;
  logic [7:0] id, od;
  logic [2:0] sh, md;

  logic        iv32, ir32, ov32, ord32, oe32;
  logic [31:0] id32, od32;
  logic [4:0]  sh32;
  logic [2:0]  md32;

  int total  = 0;
  int passes = 0;

  barrel_shifter_pipe #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv),
    .in_ready  (ir),
    .in_data   (id),
    .shamt     (sh),
    .mode      (md),
    .out_valid (ov),
    .out_ready (ord),
    .out_data  (od),
    .out_err   (oe)
  );

  barrel_shifter_pipe #(.WIDTH(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv32),
    .in_ready  (ir32),
    .in_data   (id32),
    .shamt     (sh32),
    .mode      (md32),
    .out_valid (ov32),
    .out_ready (ord32),
    .out_data  (od32),
    .out_err   (oe32)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  function automatic logic [63:0] model(
    input logic [63:0] d, input int s,
    input int m, input int w);
    logic [63:0] mask, r;
    mask = (64'd1 << w) - 64'd1;
    d = d & mask;
    case (m)
      0: r = (d << s) & mask;
      1: r = d >> s;
      2: begin
        r = d >> s;
        if (d[w-1]) r = r | (mask & ~(mask >> s));
      end
      3: r = ((d << s) | (d >> (w - s))) & mask;
      4: r = ((d >> s) | (d << (w - s))) & mask;
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic one8(input string tag,
                      input logic [7:0] d,
                      input logic [2:0] s,
                      input logic [2:0] m,
                      input logic [7:0] ed,
                      input logic ee);
    @(negedge clk);
    iv = 1'b1; id = d; sh = s; md = m;
    @(negedge clk);
    iv = 1'b0; id = $urandom; sh = $urandom; md = $urandom;
    chk({tag, "_v1"}, ov, 0);
    @(negedge clk);
    chk({tag, "_v2"}, ov, 0);
    @(negedge clk);
    chk({tag, "_v3"}, ov, 1);
    chk({tag, "_data"}, od, ed);
    chk({tag, "_err"}, oe, ee);
    @(negedge clk);
    chk({tag, "_v4"}, ov, 0);
  endtask

  logic [8:0]  q8  [$];
  logic [32:0] q32 [$];
  logic [7:0]  sd [5];
  logic [2:0]  ss [5];
  logic [2:0]  sm [5];

  initial begin
    int sent, got, cyc;
    bit held, stale, have;
    logic [7:0] hd;
    logic [8:0] e8;
    logic [32:0] e32;

    rst_n = 1'b0;
    iv = 0; id = 0; sh = 0; md = 0; ord = 0;
    iv32 = 0; id32 = 0; sh32 = 0; md32 = 0; ord32 = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", ov, 0);
    chk("rst_out_err", oe, 0);
    chk("rst_out_data", od, 0);
    chk("rst_in_ready", ir, 1);
    chk("rst_out_valid32", ov32, 0);
    rst_n = 1'b1;
    ord = 1'b1;

    one8("srl_80_4", 8'h80, 3'd4, 3'd1, 8'h08, 1'b0);
    one8("sra_80_2", 8'h80, 3'd2, 3'd2, 8'hE0, 1'b0);
    one8("sra_40_2", 8'h40, 3'd2, 3'd2, 8'h10, 1'b0);
    one8("rol_81_1", 8'h81, 3'd1, 3'd3, 8'h03, 1'b0);
    one8("ror_81_1", 8'h81, 3'd1, 3'd4, 8'hC0, 1'b0);
    one8("sll_ff_7", 8'hFF, 3'd7, 3'd0, 8'h80, 1'b0);
    one8("rol_01_7", 8'h01, 3'd7, 3'd3, 8'h80, 1'b0);
    one8("ror_01_7", 8'h01, 3'd7, 3'd4, 8'h02, 1'b0);
    one8("sra_b5_7", 8'hB5, 3'd7, 3'd2, 8'hFF, 1'b0);
    for (int m = 0; m < 5; m++) begin
      logic [7:0] r;
      r = 8'($urandom);
      one8($sformatf("sh0_m%0d", m), r, 3'd0,
           3'(m), r, 1'b0);
    end
    one8("rsv6_5a_3", 8'h5A, 3'd3, 3'd6, 8'h5A, 1'b1);
    one8("after_rsv", 8'h0F, 3'd1, 3'd0, 8'h1E, 1'b0);

    // Stream of 5 with a 4-cycle output stall
    for (int i = 0; i < 5; i++) begin
      sd[i] = 8'($urandom);
      ss[i] = 3'($urandom_range(1, 7));
      sm[i] = 3'($urandom_range(0, 4));
    end
    sent = 0; got = 0; held = 0; hd = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      ord = !(c >= 5 && c < 9);
      if (sent < 5) begin
        iv = 1; id = sd[sent]; sh = ss[sent]; md = sm[sent];
      end else iv = 0;
      #1;
      if (ov && !ord) begin
        chk("stall_in_ready", ir, 0);
        if (held) chk("stall_hold", od, hd);
        held = 1; hd = od;
      end else held = 0;
      if (ov && ord) begin
        chk("stream_nonempty", q8.size() > 0, 1);
        if (q8.size() > 0) begin
          e8 = q8.pop_front();
          chk($sformatf("stream_%0d", got), {oe, od}, e8);
        end
        got++;
      end
      if (iv && ir) begin
        q8.push_back({1'b0, 8'(model(64'(id), int'(sh),
                                     int'(md), 8))});
        sent++;
      end
    end
    chk("stream_count", got, 5);
    ord = 1;

    // Reset while three transactions are in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iv = 1; id = 8'($urandom); sh = 3'd1; md = 3'd0;
    end
    @(negedge clk);
    iv = 0;
    #1 chk("pre_rst_valid", ov, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", ov, 0);
    chk("async_rst_data", od, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", ir, 1);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov) stale = 1;
    end
    chk("no_stale", stale, 0);

    // Random WIDTH=32 stream with backpressure
    sent = 0; got = 0; cyc = 0; have = 0;
    while (got < 10000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      ord32 = ($urandom_range(0, 3) != 0);
      if (!have && sent < 10000 &&
          $urandom_range(0, 4) != 0) begin
        have = 1;
        id32 = $urandom;
        sh32 = 5'($urandom);
        md32 = 3'($urandom_range(0, 7));
      end
      iv32 = have;
      #1;
      if (ov32 && ord32) begin
        chk("r32_nonempty", q32.size() > 0, 1);
        if (q32.size() > 0) begin
          e32 = q32.pop_front();
          chk($sformatf("r32_%0d", got), {oe32, od32}, e32);
        end
        got++;
      end
      if (iv32 && ir32) begin
        q32.push_back({md32 > 3'd4,
                       32'(model(64'(id32), int'(sh32),
                                 int'(md32), 32))});
        sent++;
        have = 0;
      end
    end
    iv32 = 0;
    chk("r32_count", got, 10000);
    chk("r32_drained", q32.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
